// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS-style decode/execute datapath.
//   REG_ADDR_W : width of a register-file address
//   SEL_RT/RD/RA : destination-select encodings used by the control unit
//   RA_ADDR    : hard-wired link register ($ra) written by jal
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int          REG_ADDR_W = 5;

    localparam logic [1:0]  SEL_RT     = 2'd0;
    localparam logic [1:0]  SEL_RD     = 2'd1;
    localparam logic [1:0]  SEL_RA     = 2'd2;

    localparam logic [4:0]  RA_ADDR    = 5'd31;

endpackage

// File: rtl/reg_dst_mux_stage_mux_n.sv
// -----------------------------------------------------------------------------
// mux_n
// Purely combinational N-way selector of WIDTH-bit candidates.
// Ports:
//   in_bus_i : packed candidates, candidate i = in_bus_i[i*WIDTH +: WIDTH]
//   sel_i    : binary candidate index
//   y_o      : selected candidate, or 0 when sel_i does not name a candidate
//   oob_o    : high when sel_i >= N (no candidate selected)
// -----------------------------------------------------------------------------
module mux_n
    import mips_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W,
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic [N*WIDTH-1:0] in_bus_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic [WIDTH-1:0]   y_o,
    output logic               oob_o
);

    // Walk every legal index; a select that matches none of them leaves
    // the output at zero and raises the out-of-range flag.
    always_comb begin
        y_o   = '0;
        oob_o = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (sel_i == SEL_W'(i)) begin
                y_o   = in_bus_i[i*WIDTH +: WIDTH];
                oob_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_dst_mux_stage.sv
// -----------------------------------------------------------------------------
// reg_dst_mux_stage
// ID/EX pipeline stage that picks the destination register address out of N
// candidates (rt, rd, $ra, ...) and registers it with a valid bit.
// Per-edge priority: rst > flush > stall > load.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_bus     : packed candidates, candidate i = in_bus[i*WIDTH +: WIDTH]
//   sel        : index of the candidate to pass
//   in_valid   : qualifies in_bus/sel this cycle
//   stall      : hold stage contents
//   flush      : replace stage contents with a bubble
//   y          : registered destination address
//   out_valid  : y belongs to a live instruction
//   sel_q      : registered select
//   sel_err    : sticky, an out-of-range select was accepted while valid
// Build option:
//   ZERO_DST_SQUASH_EN : a valid load that selects a zero candidate ($zero)
//                        is marked not-valid so it creates no false hazard.
// -----------------------------------------------------------------------------
module reg_dst_mux_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W,
    parameter int N     = 3,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    output logic [SEL_W-1:0]   sel_q,
    output logic               sel_err
);

    // Reject configurations where the select cannot address every candidate.
    if (N < 2 || N > 16 || (2**SEL_W) < N) begin : gParamCheck
        $error("reg_dst_mux_stage: need 2 <= N <= 16 and 2**SEL_W >= N");
    end

    logic [WIDTH-1:0] mux_y;
    logic             mux_oob;

    logic [WIDTH-1:0] y_q,         y_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] sel_reg_q,   sel_reg_d;
    logic             sel_err_q,   sel_err_d;

    mux_n #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_mux (
        .in_bus_i (in_bus),
        .sel_i    (sel),
        .y_o      (mux_y),
        .oob_o    (mux_oob)
    );

    // Next-state: hold by default, flush inserts a bubble, otherwise load
    // unless stalled. sel_err only ever sets here; reset is the sole clear.
    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        sel_reg_d   = sel_reg_q;
        sel_err_d   = sel_err_q;
        if (flush) begin
            y_d         = '0;
            out_valid_d = 1'b0;
            sel_reg_d   = '0;
        end else if (!stall) begin
            y_d       = mux_y;
            sel_reg_d = sel;
`ifdef ZERO_DST_SQUASH_EN
            // A write to $zero is architecturally a no-op, so drop its valid.
            out_valid_d = in_valid && !(!mux_oob && (mux_y == '0));
`else
            out_valid_d = in_valid;
`endif
            if (in_valid && mux_oob) begin
                sel_err_d = 1'b1;
            end
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            sel_reg_q   <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            sel_reg_q   <= sel_reg_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign sel_q     = sel_reg_q;
    assign sel_err   = sel_err_q;

endmodule
